// File: rtl/comp_sweep_pkg.sv
// Shared definitions for the comparator sweep checker: FSM encoding and
// bit positions of the {greater, lesser, equal} response vector.
package comp_sweep_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WAIT  = ST_WAIT,
    CHECK = ST_CHECK,
    DONE  = ST_DONE
  } state_t;

  localparam int GT = 2;
  localparam int LT = 1;
  localparam int EQ = 0;

endpackage

// File: rtl/comp_sweep_checker_if.sv
// Bus between the sweep checker and its comparator under test / host.
// master = checker side, slave = CUT/host side.
interface comp_sweep_checker_if #(
  parameter int WIDTH = 2
);
  logic             start;
  logic             greater_in;
  logic             lesser_in;
  logic             equal_in;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [2*WIDTH:0] err_count;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;

  modport master (
    input  start, greater_in, lesser_in, equal_in,
    output a_out, b_out, busy, done, pass, err_count, fail_a, fail_b
  );

  modport slave (
    output start, greater_in, lesser_in, equal_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_a, fail_b
  );
endinterface

// File: rtl/comp_ref_model.sv
// Combinational unsigned reference comparator producing the expected
// {greater, lesser, equal} response for the current operand pair.
module comp_ref_model
  import comp_sweep_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       exp_vec
);

  always_comb begin
    exp_vec     = '0;
    exp_vec[GT] = (a > b);
    exp_vec[LT] = (a < b);
    exp_vec[EQ] = (a == b);
  end

endmodule

// File: rtl/comp_sweep_checker.sv
// Exhaustive sweep driver/checker for a WIDTH-bit magnitude comparator.
// Optional: define COMP_SWEEP_STOP_ON_FAIL_EN to end the sweep on the first mismatch.
module comp_sweep_checker
  import comp_sweep_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  comp_sweep_checker_if.master bus
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WIDTH-1:0] OP_MAX  = '1;
  localparam logic [2*WIDTH:0] ERR_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic [WIDTH-1:0] a_q, b_q, fail_a_q, fail_b_q;
  logic [2*WIDTH:0] err_q;
  logic             busy_q, done_q, pass_q;

  logic [2:0] exp_vec;
  logic [2:0] resp_vec;
  logic       settled, last_vec, mismatch;
  logic       load, check, finish;

  comp_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a       (a_q),
    .b       (b_q),
    .exp_vec (exp_vec)
  );

  always_comb begin
    resp_vec     = '0;
    resp_vec[GT] = bus.greater_in;
    resp_vec[LT] = bus.lesser_in;
    resp_vec[EQ] = bus.equal_in;
  end

  assign settled  = (settle_cnt == CNT_W'(SETTLE - 1));
  assign last_vec = (a_q == OP_MAX) && (b_q == OP_MAX);
  assign mismatch = (resp_vec != exp_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    check     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (settled) state_nxt = CHECK;
      end
      CHECK: begin
        check = 1'b1;
`ifdef COMP_SWEEP_STOP_ON_FAIL_EN
        finish = last_vec || mismatch;
`else
        finish = last_vec;
`endif
        state_nxt = finish ? DONE : WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      a_q        <= '0;
      b_q        <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      settle_cnt <= (state == WAIT && !settled) ? settle_cnt + CNT_W'(1) : '0;
      if (load) begin
        a_q      <= '0;
        b_q      <= '0;
        fail_a_q <= '0;
        fail_b_q <= '0;
        err_q    <= '0;
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
        pass_q   <= 1'b0;
      end else if (check) begin
        if (mismatch) begin
          if (err_q == '0) begin
            fail_a_q <= a_q;
            fail_b_q <= b_q;
          end
          if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
        end
        if (finish) begin
          // Operands stay on the last (or failing) vector while in DONE.
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= !mismatch && (err_q == '0);
        end else begin
          b_q <= (b_q == OP_MAX) ? '0 : b_q + 1'b1;
          if (b_q == OP_MAX) a_q <= a_q + 1'b1;
        end
      end
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_a    = fail_a_q;
  assign bus.fail_b    = fail_b_q;

endmodule
